// File: rtl/turn_pkg.sv
// Shared definitions for the turn scheduler: state codes, player count and
// the default wait-for-key limit.
package turn_pkg;
  localparam int NPLAYER = 4;
  localparam logic [25:0] TIMEOUT_DEF = 26'd50_000_000;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_WAIT_KEY = 3'd2,
    S_BUSY     = 3'd3,
    S_DONE     = 3'd4
  } state_t;
endpackage

// File: rtl/turn_timer.sv
// Wait-for-key counter: counts while enabled and flags the last cycle a
// player may still press before losing the turn.
module turn_timer import turn_pkg::*; #(
  parameter int unsigned     TO_W    = 26,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(TIMEOUT_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam logic [TO_W-1:0] LAST = TIMEOUT - TO_W'(1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TO_W'(1);
    end
  end

  assign expire = enable && (count == LAST);
endmodule

// File: rtl/turn_scheduler.sv
// Round-robin turn scheduler for a four-player game: picks the next active
// player, waits for that player's key with a timeout, then hands off the move.
module turn_scheduler import turn_pkg::*; #(
  parameter int unsigned     TO_W    = 26,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(TIMEOUT_DEF)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] active,
  input  logic [3:0] req,
  input  logic       turn_done,
  input  logic       hit,
  input  logic       win,
  output logic [3:0] grant,
  output logic [1:0] cur_player,
  output logic       turn_start,
  output logic       timeout,
  output logic       game_over,
  output logic [2:0] state
);
  // state    | meaning
  // IDLE     | no game running, waiting for start
  // SELECT   | one cycle: pick next active player after the pointer
  // WAIT_KEY | granted player must press its key before the timer expires
  // BUSY     | move handed to the game controller, waiting for turn_done
  // DONE     | game finished, grant shows the winner (0 if nobody active)

  state_t     st;
  logic [1:0] ptr;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       pick_ok;
  logic       in_wait;
  logic       expire;

  assign state   = st;
  assign in_wait = (st == S_WAIT_KEY);

  turn_timer #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait),
    .enable (in_wait),
    .expire (expire)
  );

  // Search order ptr+1 .. ptr+4, so the current player is considered last.
  always_comb begin
    pick    = ptr;
    pick_ok = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NPLAYER; k++) begin
      cand = ptr + 2'(k);
      if (!pick_ok && active[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= S_IDLE;
      grant      <= 4'b0000;
      cur_player <= 2'd0;
      ptr        <= 2'd3;
      turn_start <= 1'b0;
      timeout    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      turn_start <= 1'b0;
      timeout    <= 1'b0;
      game_over  <= 1'b0;
      case (st)
        S_IDLE: begin
          grant <= 4'b0000;
          if (start) begin
            ptr <= 2'd3;
            st  <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (pick_ok) begin
            grant      <= 4'b0001 << pick;
            cur_player <= pick;
            ptr        <= pick;
            st         <= S_WAIT_KEY;
          end else begin
            grant     <= 4'b0000;
            game_over <= 1'b1;
            st        <= S_DONE;
          end
        end
        S_WAIT_KEY: begin
          if (req[cur_player]) begin
            turn_start <= 1'b1;
            st         <= S_BUSY;
          end else if (!active[cur_player]) begin
            grant <= 4'b0000;
            st    <= S_SELECT;
          end else if (expire) begin
            grant   <= 4'b0000;
            timeout <= 1'b1;
            st      <= S_SELECT;
          end
        end
        S_BUSY: begin
          if (turn_done) begin
            if (win) begin
              game_over <= 1'b1;
              st        <= S_DONE;
            end else if (hit) begin
              st <= S_WAIT_KEY;
            end else begin
              grant <= 4'b0000;
              st    <= S_SELECT;
            end
          end
        end
        S_DONE: begin
          game_over <= 1'b1;
          if (start) begin
            game_over <= 1'b0;
            grant     <= 4'b0000;
            ptr       <= 2'd3;
            st        <= S_SELECT;
          end
        end
        default: begin
          grant <= 4'b0000;
          st    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: directed scenarios plus randomized games checked
// against a transaction-level model of the round-robin rules.
module tb_turn_scheduler;
  localparam int TO = 8;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_SEL = 3'd1, ST_WAIT = 3'd2,
                         ST_BUSY = 3'd3, ST_DONE = 3'd4;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic       turn_done = 1'b0, hit = 1'b0, win = 1'b0;
  logic [3:0] active = 4'b0000, req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] cur_player;
  logic       turn_start, timeout, game_over;
  logic [2:0] state;
  logic [9:0] obs;

  int   tests_run = 0, tests_failed = 0;
  logic mon_en = 1'b0, prev_ts = 1'b0, prev_to = 1'b0;

  turn_scheduler #(.TIMEOUT(26'd8)) dut (
    .clk(clk), .rst(rst), .start(start), .active(active), .req(req),
    .turn_done(turn_done), .hit(hit), .win(win), .grant(grant),
    .cur_player(cur_player), .turn_start(turn_start), .timeout(timeout),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, grant, turn_start, timeout, game_over};

  function automatic logic [9:0] ev(input logic [2:0] st, input logic [3:0] g,
                                    input logic ts, input logic to, input logic go);
    return {st, g, ts, to, go};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; active = 4'b0000; req = 4'b0000;
    turn_done = 1'b0; hit = 1'b0; win = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  // Pulse and grant invariants checked on every falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      tests_run++;
      if ((turn_start && timeout) || (turn_start && prev_ts) || (timeout && prev_to)) begin
        tests_failed++;
        $display("FAIL pulse_rule: ts=%b to=%b prev_ts=%b prev_to=%b, want isolated single pulses",
                 turn_start, timeout, prev_ts, prev_to);
      end
      tests_run++;
      if (((state == ST_WAIT || state == ST_BUSY) && !$onehot(grant)) ||
          ((state == ST_IDLE || state == ST_SEL) && grant !== 4'b0000)) begin
        tests_failed++;
        $display("FAIL grant_rule: state=%0d grant=%b, want one-hot in WAIT/BUSY, zero in IDLE/SELECT",
                 state, grant);
      end
    end
    prev_ts <= turn_start;
    prev_to <= timeout;
  end

  task automatic test_reset();
    logic [9:0] e;
    rst = 1'b0;
    #1;
    e = ev(ST_IDLE, 4'b0000, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e || cur_player !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_async: got %b cur=%0d want %b cur=0", obs, cur_player, e);
    end
    tick(2);
    rst = 1'b1;
    tick(2);
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL reset_idle_hold: got %b want %b", obs, e);
    end
  endtask

  task automatic test_basic();
    logic [9:0] e;
    do_reset();
    active = 4'b1111; start = 1'b1;
    tick(); start = 1'b0;
    e = ev(ST_SEL, 4'b0000, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL basic_select: got %b want %b", obs, e); end
    tick();
    e = ev(ST_WAIT, 4'b0001, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e || cur_player !== 2'd0) begin
      tests_failed++; $display("FAIL basic_grant0: got %b cur=%0d want %b cur=0", obs, cur_player, e);
    end
    req = 4'b0001;
    tick(); req = 4'b0000;
    e = ev(ST_BUSY, 4'b0001, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL basic_turn_start: got %b want %b", obs, e); end
    tick();
    e = ev(ST_BUSY, 4'b0001, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL basic_busy_hold: got %b want %b", obs, e); end
    turn_done = 1'b1;
    tick(); turn_done = 1'b0;
    e = ev(ST_SEL, 4'b0000, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL basic_miss_select: got %b want %b", obs, e); end
    tick();
    e = ev(ST_WAIT, 4'b0010, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e || cur_player !== 2'd1) begin
      tests_failed++; $display("FAIL basic_grant1: got %b cur=%0d want %b cur=1", obs, cur_player, e);
    end
  endtask

  task automatic test_skip();
    logic [9:0] e;
    do_reset();
    active = 4'b1010; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    e = ev(ST_WAIT, 4'b0010, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL skip_first: got %b want %b", obs, e); end
    req = 4'b0010; tick(); req = 4'b0000;
    turn_done = 1'b1; tick(); turn_done = 1'b0;
    tick();
    e = ev(ST_WAIT, 4'b1000, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL skip_to_3: got %b want %b", obs, e); end
    req = 4'b1000; tick(); req = 4'b0000;
    turn_done = 1'b1; tick(); turn_done = 1'b0;
    tick();
    e = ev(ST_WAIT, 4'b0010, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL skip_wrap_to_1: got %b want %b", obs, e); end
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    do_reset();
    active = 4'b1111; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    for (int c = 1; c < TO; c++) begin
      tick();
      e = ev(ST_WAIT, 4'b0001, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (obs !== e) begin tests_failed++; $display("FAIL to_waiting c=%0d: got %b want %b", c, obs, e); end
    end
    tick();
    e = ev(ST_SEL, 4'b0000, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL to_pulse: got %b want %b", obs, e); end
    tick();
    e = ev(ST_WAIT, 4'b0010, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL to_next_player: got %b want %b", obs, e); end
    tick(TO - 1);
    req = 4'b0010;
    tick(); req = 4'b0000;
    e = ev(ST_BUSY, 4'b0010, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL to_key_on_last: got %b want %b", obs, e); end
  endtask

  task automatic test_win();
    logic [9:0] e;
    do_reset();
    active = 4'b0110; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    req = 4'b0010; tick(); req = 4'b0000;
    turn_done = 1'b1; hit = 1'b1;
    tick(); turn_done = 1'b0; hit = 1'b0;
    e = ev(ST_WAIT, 4'b0010, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL hit_same_player: got %b want %b", obs, e); end
    tick(TO - 1);
    e = ev(ST_WAIT, 4'b0010, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL hit_timer_cleared: got %b want %b", obs, e); end
    req = 4'b0010; tick(); req = 4'b0000;
    turn_done = 1'b1; hit = 1'b1; win = 1'b1;
    tick(); turn_done = 1'b0; hit = 1'b0; win = 1'b0;
    e = ev(ST_DONE, 4'b0010, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL win_done: got %b want %b", obs, e); end
    tick(2);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL win_hold: got %b want %b", obs, e); end
    active = 4'b1111; start = 1'b1;
    tick(); start = 1'b0;
    e = ev(ST_SEL, 4'b0000, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL restart_select: got %b want %b", obs, e); end
    tick();
    e = ev(ST_WAIT, 4'b0001, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL restart_grant0: got %b want %b", obs, e); end
  endtask

  task automatic test_empty_and_reset();
    logic [9:0] e;
    do_reset();
    active = 4'b0000; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    e = ev(ST_DONE, 4'b0000, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL empty_done: got %b want %b", obs, e); end
    active = 4'b1111; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    req = 4'b0001; tick(); req = 4'b0000;
    tick();
    #2; rst = 1'b0;
    #1;
    e = ev(ST_IDLE, 4'b0000, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e || cur_player !== 2'd0) begin
      tests_failed++; $display("FAIL rst_in_busy: got %b cur=%0d want %b cur=0", obs, cur_player, e);
    end
    tick(2);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (obs !== e) begin tests_failed++; $display("FAIL rst_quiet c=%0d: got %b want %b", c, obs, e); end
    end
  endtask

  task automatic test_req_filter();
    logic [9:0] e;
    do_reset();
    active = 4'b1111; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    for (int p = 0; p < 2; p++) begin
      req = 4'(1 << p); tick(); req = 4'b0000;
      turn_done = 1'b1; tick(); turn_done = 1'b0;
      tick();
    end
    req = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      tick();
      e = ev(ST_WAIT, 4'b0100, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (obs !== e) begin tests_failed++; $display("FAIL filter_others c=%0d: got %b want %b", c, obs, e); end
    end
    req = 4'b1111;
    tick(); req = 4'b0000;
    e = ev(ST_BUSY, 4'b0100, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e || cur_player !== 2'd2) begin
      tests_failed++; $display("FAIL filter_accept: got %b cur=%0d want %b cur=2", obs, cur_player, e);
    end
    turn_done = 1'b1; hit = 1'b1;
    tick(); turn_done = 1'b0; hit = 1'b0;
    active = 4'b1011;
    tick();
    e = ev(ST_SEL, 4'b0000, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL drop_select: got %b want %b", obs, e); end
    tick();
    e = ev(ST_WAIT, 4'b1000, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e) begin tests_failed++; $display("FAIL drop_next: got %b want %b", obs, e); end
  endtask

  // Model: pointer plus active mask; the next player is the first active one
  // scanning pointer+1 .. pointer+4 modulo 4.
  task automatic test_random();
    logic [9:0] e;
    logic [3:0] m_active, g;
    int m_ptr, pick, r, d, o;
    bit over, sel;
    for (int gm = 0; gm < 40; gm++) begin
      do_reset();
      m_active = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      active = m_active; m_ptr = 3;
      start = 1'b1; tick(); start = 1'b0;
      over = 1'b0; sel = 1'b1;
      for (int t = 0; t < 12 && !over; t++) begin
        if (sel) begin
          pick = -1;
          for (int k = 1; k <= 4; k++)
            if (pick < 0 && m_active[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
          tick();
          if (pick < 0) begin
            e = ev(ST_DONE, 4'b0000, 1'b0, 1'b0, 1'b1);
            tests_run++;
            if (obs !== e) begin tests_failed++; $display("FAIL rnd_empty_done: got %b want %b", obs, e); end
            over = 1'b1;
            continue;
          end
          m_ptr = pick;
          e = ev(ST_WAIT, 4'(1 << pick), 1'b0, 1'b0, 1'b0);
          tests_run++;
          if (obs !== e || cur_player !== 2'(pick)) begin
            tests_failed++;
            $display("FAIL rnd_grant: got %b cur=%0d want %b cur=%0d", obs, cur_player, e, pick);
          end
          sel = 1'b0;
        end
        g = 4'(1 << m_ptr);
        r = $urandom_range(0, 5);
        d = (r <= 3) ? $urandom_range(0, TO - 1) : (r == 4) ? TO - 1 : $urandom_range(0, TO - 1);
        for (int c = 0; c < d; c++) begin
          m_active = 4'($urandom_range(0, 15)) | g; active = m_active;
          req = 4'($urandom_range(0, 15)) & ~g;
          tick();
          e = ev(ST_WAIT, g, 1'b0, 1'b0, 1'b0);
          tests_run++;
          if (obs !== e) begin tests_failed++; $display("FAIL rnd_wait: got %b want %b", obs, e); end
        end
        if (r <= 3) begin
          req = 4'($urandom_range(0, 15)) | g;
          tick(); req = 4'b0000;
          e = ev(ST_BUSY, g, 1'b1, 1'b0, 1'b0);
          tests_run++;
          if (obs !== e) begin tests_failed++; $display("FAIL rnd_key: got %b want %b", obs, e); end
          for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
            m_active = 4'($urandom_range(0, 15)) | g; active = m_active;
            req = 4'($urandom_range(0, 15));
            tick();
            e = ev(ST_BUSY, g, 1'b0, 1'b0, 1'b0);
            tests_run++;
            if (obs !== e) begin tests_failed++; $display("FAIL rnd_busy: got %b want %b", obs, e); end
          end
          req = 4'b0000;
          o = $urandom_range(0, 5);
          turn_done = 1'b1; win = (o == 0); hit = (o == 0) ? 1'($urandom_range(0, 1)) : (o <= 2);
          tick(); turn_done = 1'b0; win = 1'b0; hit = 1'b0;
          if (o == 0) begin
            e = ev(ST_DONE, g, 1'b0, 1'b0, 1'b1);
            over = 1'b1;
          end else if (o <= 2) begin
            e = ev(ST_WAIT, g, 1'b0, 1'b0, 1'b0);
          end else begin
            e = ev(ST_SEL, 4'b0000, 1'b0, 1'b0, 1'b0);
            sel = 1'b1;
          end
          tests_run++;
          if (obs !== e) begin tests_failed++; $display("FAIL rnd_turn_done o=%0d: got %b want %b", o, obs, e); end
        end else if (r == 4) begin
          req = 4'($urandom_range(0, 15)) & ~g;
          tick(); req = 4'b0000;
          e = ev(ST_SEL, 4'b0000, 1'b0, 1'b1, 1'b0);
          tests_run++;
          if (obs !== e) begin tests_failed++; $display("FAIL rnd_timeout: got %b want %b", obs, e); end
          sel = 1'b1;
        end else begin
          m_active = 4'($urandom_range(0, 15)) & ~g; active = m_active;
          req = 4'($urandom_range(0, 15)) & ~g;
          tick(); req = 4'b0000;
          e = ev(ST_SEL, 4'b0000, 1'b0, 1'b0, 1'b0);
          tests_run++;
          if (obs !== e) begin tests_failed++; $display("FAIL rnd_drop d=%0d: got %b want %b", d, obs, e); end
          sel = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    mon_en = 1'b1;
    test_basic();
    test_skip();
    test_timeout();
    test_win();
    test_empty_and_reset();
    test_req_filter();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/turn_scheduler.md
TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 26'd50_000_000, wait-for-key limit in clk cycles (1 s at 50 MHz).
REQ-002 Parameter TO_W, default 26, width of the timeout counter.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level-sampled game start/restart request.
REQ-006 active  input  4  per-player still-in-game mask, bit i = player i.
REQ-007 req  input  4  per-player key-press, bit i = player i, level.
REQ-008 turn_done  input  1  one-cycle pulse from game controller ending the current move.
REQ-009 hit  input  1  qualifies turn_done: 1 = correct tile, same player continues.
REQ-010 win  input  1  qualifies turn_done: 1 = current player has won.
REQ-011 grant  output  4  one-hot current player, registered.
REQ-012 cur_player  output  2  binary index of grant, registered.
REQ-013 turn_start  output  1  one-cycle pulse, accepted key-press hands the move to the game controller.
REQ-014 timeout  output  1  one-cycle pulse, current player lost turn by inactivity.
REQ-015 game_over  output  1  high while in DONE.
REQ-016 state  output  3  current FSM state encoding, for debug/LEDs.

Function
REQ-017 States SHALL be IDLE=0, SELECT=1, WAIT_KEY=2, BUSY=3, DONE=4; codes 5-7 SHALL return to IDLE next cycle.
REQ-018 IDLE: start=1 -> SELECT; round-robin pointer set to 3 so player 0 is examined first.
REQ-019 SELECT (exactly 1 cycle): next player = first i in order p+1, p+2, p+3, p (mod 4) with active[i]=1; load grant/cur_player, pointer p := i -> WAIT_KEY; active=4'b0000 -> DONE with grant=0.
REQ-020 WAIT_KEY: timer counts up from 0 each cycle; req[cur_player]=1 -> BUSY with turn_start pulsed the same edge; req bits of other players SHALL be ignored.
REQ-021 WAIT_KEY: timer reaching TIMEOUT-1 without key -> timeout pulse, SELECT; key and expiry in same cycle -> key wins, no timeout.
REQ-022 WAIT_KEY: active[cur_player] falling to 0 -> SELECT without timeout pulse.
REQ-023 BUSY: hold grant; turn_done=1 and win=1 -> DONE (win has priority over hit); turn_done=1, hit=1 -> WAIT_KEY, same player, timer cleared; turn_done=1, hit=0 -> SELECT.
REQ-024 BUSY: active changes and req SHALL be ignored until turn_done.
REQ-025 DONE: grant holds winner (0 if entered from empty mask), game_over=1; start=1 -> SELECT with pointer reset to 3.
REQ-026 grant SHALL be 0 in IDLE and SELECT, exactly one-hot in WAIT_KEY and BUSY.
REQ-027 turn_start and timeout SHALL never be high in the same cycle, nor for more than one consecutive cycle.
REQ-028 Latency: key to turn_start 1 cycle; turn_done(hit=0) to new grant 2 cycles.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, grant=0, cur_player=0, pointer=3, timer=0, turn_start=0, timeout=0, game_over=0, independent of clk.
REQ-030 Reset asserted mid-turn SHALL discard the turn; no pulse output after release until new stimulus.

Structure
REQ-031 Package turn_pkg SHALL hold state encodings, NPLAYER=4 and TIMEOUT default.
REQ-032 Sub-module turn_timer (clear, enable, expire pulse, TO_W/TIMEOUT parameters) SHALL implement the wait counter; round-robin pick stays inline.

Verification
REQ-033 TIMEOUT=8, active=1111, start -> grants 0001 in WAIT_KEY; req=0001 -> turn_start 1 cycle later; turn_done,hit=0 -> grant 0010.
REQ-034 active=1010, pointer at player 1, turn_done,hit=0 -> grant skips 0100, becomes 1000; next miss -> 0010.
REQ-035 TIMEOUT=8, no req for 8 cycles in WAIT_KEY -> single timeout pulse, grant advances; req on 8th cycle -> turn_start, no timeout.
REQ-036 BUSY, turn_done=1, hit=1, win=1 -> DONE, game_over=1, grant=winner; start -> grant 0001.
REQ-037 active=0000 at start -> DONE, grant=0000; rst low in BUSY -> IDLE, all outputs 0 asynchronously.
REQ-038 req=1111 in WAIT_KEY for player 2 -> only player 2 accepted; req=1011 -> no turn_start.
